// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, truncating.
// Ports: clk, rst (async, active-high), in_valid/in_ready + dividend/divisor
// operand handshake, out_valid/out_ready + quotient/remainder/overflow/
// div_zero result handshake. Optional build macro DIV_SATURATE_EN clamps the
// quotient on overflow instead of wrapping to its low N bits.
module booth_divider #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           overflow,
  output logic           div_zero
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Largest positive / negative quotient magnitudes that fit in N bits.
  localparam logic [W-1:0] QPOS = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [W-1:0] QNEG = QPOS + W'(1);

  logic [1:0]    state;
  logic [W-1:0]  qm;
  logic [N-1:0]  rm;
  logic [N-1:0]  dm;
  logic          qs;
  logic          rs;
  logic [CW-1:0] cnt;

  logic [W-1:0]  dvd_abs;
  logic [N-1:0]  dvs_abs;
  logic [N:0]    sh;
  logic          ge;
  logic [N-1:0]  rnext;
  logic          ovf;
  logic [N-1:0]  qfix;
  logic [N-1:0]  rfix;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    dvd_abs = dividend[W-1] ? -dividend : dividend;
    dvs_abs = divisor[N-1] ? -divisor : divisor;
    // qm holds unconsumed dividend bits on top, quotient bits fill below.
    sh = {rm, qm[W-1]};
    ge = (sh >= {1'b0, dm});
    // Partial remainder stays below dm, so N-bit modular subtract is exact.
    rnext = ge ? (sh[N-1:0] - dm) : sh[N-1:0];
    ovf  = qs ? (qm > QNEG) : (qm > QPOS);
    qfix = qs ? -qm[N-1:0] : qm[N-1:0];
    rfix = rs ? -rm : rm;
`ifdef DIV_SATURATE_EN
    if (ovf) begin
      qfix = qs ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      qm        <= '0;
      rm        <= '0;
      dm        <= '0;
      qs        <= 1'b0;
      rs        <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            qm  <= dvd_abs;
            rm  <= '0;
            dm  <= dvs_abs;
            qs  <= dividend[W-1] ^ divisor[N-1];
            rs  <= dividend[W-1];
            cnt <= '0;
            if (divisor == '0) begin
              quotient  <= '0;
              remainder <= '0;
              overflow  <= 1'b0;
              div_zero  <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          qm  <= {qm[W-2:0], ge};
          rm  <= rnext;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= qfix;
          remainder <= rfix;
          overflow  <= ovf;
          div_zero  <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
